// File: rtl/router_preprocess_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_preprocess_ctrl_pkg
// Description : Shared router definitions: header-parser state encoding and
//               word-index constants. Used by the preprocess controller and
//               by downstream filters that key off the same word positions.
// Revision    : 1.0 - initial release
// ============================================================================
package router_preprocess_ctrl_pkg;

    // Parser state. Each WORD_n state means "the next data word is word n".
    typedef enum logic [2:0] {
        ST_MODULE_HDRS = 3'd0,
        ST_WORD_1      = 3'd1,
        ST_WORD_2      = 3'd2,
        ST_WORD_3      = 3'd3,
        ST_WORD_4      = 3'd4,
        ST_WAIT_EOP    = 3'd5
    } state_t;

    // Word positions within a packet (after the module headers).
    localparam int unsigned WORD_ETH_DST      = 0;
    localparam int unsigned WORD_ETH_SRC_TYPE = 1;
    localparam int unsigned WORD_IP_LEN_ID    = 2;
    localparam int unsigned WORD_IP_SRC_DST   = 3;
    localparam int unsigned WORD_IP_DST_LO    = 4;
    localparam int unsigned NUM_HDR_WORDS     = 5;

    // State reached after a data word is accepted in state s.
    function automatic state_t next_word_state(input state_t s);
        state_t n;
        case (s)
            ST_MODULE_HDRS: n = ST_WORD_1;
            ST_WORD_1:      n = ST_WORD_2;
            ST_WORD_2:      n = ST_WORD_3;
            ST_WORD_3:      n = ST_WORD_4;
            ST_WORD_4:      n = ST_WAIT_EOP;
            default:        n = ST_WAIT_EOP;
        endcase
        return n;
    endfunction

endpackage : router_preprocess_ctrl_pkg
`default_nettype wire

// File: rtl/router_preprocess_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : router_preprocess_ctrl
// Description : Passive observer on the router pipeline bus. Tracks the word
//               position inside each packet and raises a one-hot strobe in
//               the same cycle as Ethernet/IP header words 0..4 appear on
//               in_data. Counts packets that reached word 4 and flags packets
//               that ended before it.
// Ports       :
//   clk                 - clock, rising edge
//   reset               - asynchronous reset, active low
//   in_data/ctrl/wr     - observed pipeline bus (never stalled or modified)
//   word_ETH_DST .. word_IP_DST_LO - combinational word strobes
//   pkt_short           - registered one-cycle pulse, EOP before word 4
//   pkt_count           - registered count of packets with word 4 seen
// Revision    : 1.0 - initial release
// ============================================================================
module router_preprocess_ctrl
    import router_preprocess_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  word_ETH_DST,
    output logic                  word_ETH_SRC_TYPE,
    output logic                  word_IP_LEN_ID,
    output logic                  word_IP_SRC_DST,
    output logic                  word_IP_DST_LO,
    output logic                  pkt_short,
    output logic [31:0]           pkt_count
);

    state_t                     state_q;
    logic                       armed_q;
    logic                       pkt_short_q;
    logic [31:0]                pkt_count_q;

    logic                       w_data_word;
    logic                       w_ctrl_word;
    logic [NUM_HDR_WORDS-1:0]   w_strobe;

    // The payload itself is only observed by downstream logic.
    logic                       unused_data;
    assign unused_data = ^in_data;

    assign w_data_word = in_wr && (in_ctrl == '0);
    assign w_ctrl_word = in_wr && (in_ctrl != '0);

    // Strobes decode straight from the registered state so they line up with
    // the word currently on in_data. Word 0 additionally needs armed_q: after
    // reset the bus may be mid-packet, and its trailing data words must not
    // be mistaken for a fresh word 0 until a ctrl word has been seen.
    always_comb begin
        w_strobe = '0;
        case (state_q)
            ST_MODULE_HDRS: w_strobe[WORD_ETH_DST]      = w_data_word && armed_q;
            ST_WORD_1:      w_strobe[WORD_ETH_SRC_TYPE] = w_data_word;
            ST_WORD_2:      w_strobe[WORD_IP_LEN_ID]    = w_data_word;
            ST_WORD_3:      w_strobe[WORD_IP_SRC_DST]   = w_data_word;
            ST_WORD_4:      w_strobe[WORD_IP_DST_LO]    = w_data_word;
            default:        w_strobe = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_MODULE_HDRS;
            armed_q     <= 1'b0;
            pkt_short_q <= 1'b0;
            pkt_count_q <= 32'd0;
        end else begin
            pkt_short_q <= 1'b0;

            // Any header or EOP word marks a packet boundary we can trust.
            if (w_ctrl_word) begin
                armed_q <= 1'b1;
            end

            // Natural 32-bit wrap from 0xFFFFFFFF to 0.
            if (w_strobe[WORD_IP_DST_LO]) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end

            case (state_q)
                ST_MODULE_HDRS: begin
                    if (w_data_word && armed_q) begin
                        state_q <= ST_WORD_1;
                    end
                end
                ST_WORD_1, ST_WORD_2, ST_WORD_3, ST_WORD_4: begin
                    if (w_data_word) begin
                        state_q <= next_word_state(state_q);
                    end else if (w_ctrl_word) begin
                        // Packet ended before its last header word.
                        state_q     <= ST_MODULE_HDRS;
                        pkt_short_q <= 1'b1;
                    end
                end
                ST_WAIT_EOP: begin
                    if (w_ctrl_word) begin
                        state_q <= ST_MODULE_HDRS;
                    end
                end
                default: begin
                    state_q <= ST_MODULE_HDRS;
                end
            endcase
        end
    end

    assign word_ETH_DST      = w_strobe[WORD_ETH_DST];
    assign word_ETH_SRC_TYPE = w_strobe[WORD_ETH_SRC_TYPE];
    assign word_IP_LEN_ID    = w_strobe[WORD_IP_LEN_ID];
    assign word_IP_SRC_DST   = w_strobe[WORD_IP_SRC_DST];
    assign word_IP_DST_LO    = w_strobe[WORD_IP_DST_LO];
    assign pkt_short         = pkt_short_q;
    assign pkt_count         = pkt_count_q;

endmodule : router_preprocess_ctrl
`default_nettype wire

// File: tb/tb_router_preprocess_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_preprocess_ctrl
// Description : Directed self-checking bench for router_preprocess_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_preprocess_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        word_ETH_DST;
    logic        word_ETH_SRC_TYPE;
    logic        word_IP_LEN_ID;
    logic        word_IP_SRC_DST;
    logic        word_IP_DST_LO;
    logic        pkt_short;
    logic [31:0] pkt_count;
    logic [4:0]  strobes;

    int n_tests = 0;
    int n_fail  = 0;

    router_preprocess_ctrl #(
        .DATA_WIDTH (64),
        .CTRL_WIDTH (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_ctrl           (in_ctrl),
        .in_wr             (in_wr),
        .word_ETH_DST      (word_ETH_DST),
        .word_ETH_SRC_TYPE (word_ETH_SRC_TYPE),
        .word_IP_LEN_ID    (word_IP_LEN_ID),
        .word_IP_SRC_DST   (word_IP_SRC_DST),
        .word_IP_DST_LO    (word_IP_DST_LO),
        .pkt_short         (pkt_short),
        .pkt_count         (pkt_count)
    );

    assign strobes = {word_IP_DST_LO, word_IP_SRC_DST, word_IP_LEN_ID,
                      word_ETH_SRC_TYPE, word_ETH_DST};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus word; strobes are sampled at the falling edge, mid-cycle.
    task automatic bus_word(input logic [7:0] ctrl, input logic [4:0] exp, input string tag);
        in_wr   = 1'b1;
        in_ctrl = ctrl;
        in_data = {$urandom, $urandom};
        @(negedge clk);
        check(tag, 64'(strobes), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: ctrl==0 on the bus but in_wr low, so nothing may strobe.
    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            in_wr   = 1'b0;
            in_ctrl = 8'h00;
            in_data = {$urandom, $urandom};
            @(negedge clk);
            check(tag, 64'(strobes), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // nhdr headers (0xFF), then ndata words whose last carries eop.
    // Data word i (ctrl==0) is expected to strobe bit i for i<5.
    task automatic send_pkt(input int nhdr, input int ndata, input logic [7:0] eop,
                            input int gap, input string tag);
        for (int h = 0; h < nhdr; h++) begin
            bus_word(8'hFF, 5'd0, {tag, "_hdr"});
            if (gap > 0) idle(gap, {tag, "_gap"});
        end
        for (int i = 0; i < ndata; i++) begin
            if (i == ndata - 1) begin
                bus_word(eop, 5'd0, {tag, "_eop"});
            end else begin
                bus_word(8'h00, (i < 5) ? 5'(1 << i) : 5'd0, {tag, "_data"});
                if (gap > 0) idle(gap, {tag, "_gap"});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset asserted with a data word on the bus: no strobe allowed.
        reset   = 1'b0;
        in_wr   = 1'b1;
        in_ctrl = 8'h00;
        in_data = 64'h0;
        @(negedge clk);
        check("rst_strobes", 64'(strobes), 64'd0);
        check("rst_short", 64'(pkt_short), 64'd0);
        check("rst_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1, "post_rst_idle");

        // Basic packet: 2 headers, 8 data words, EOP 0x01.
        send_pkt(2, 8, 8'h01, 0, "t1");
        check("t1_short", 64'(pkt_short), 64'd0);
        check("t1_count", 64'(pkt_count), 64'd1);
        idle(1, "t1_idle");

        // Same packet with 3-cycle gaps between every word.
        send_pkt(2, 8, 8'h01, 3, "t2");
        check("t2_short", 64'(pkt_short), 64'd0);
        check("t2_count", 64'(pkt_count), 64'd2);
        idle(1, "t2_idle");

        // Short packet: EOP (0x04) on third data word.
        send_pkt(2, 3, 8'h04, 0, "t3");
        check("t3_short_pulse", 64'(pkt_short), 64'd1);
        check("t3_count", 64'(pkt_count), 64'd2);
        idle(1, "t3_idle");
        check("t3_short_clear", 64'(pkt_short), 64'd0);
        send_pkt(1, 6, 8'h01, 0, "t3_next");
        check("t3_next_count", 64'(pkt_count), 64'd3);
        idle(1, "t3_next_idle");

        // Reset asserted while word 2 is on the bus.
        bus_word(8'hFF, 5'd0, "t4_hdr");
        bus_word(8'h00, 5'b00001, "t4_w0");
        bus_word(8'h00, 5'b00010, "t4_w1");
        in_ctrl = 8'h00;
        in_data = {$urandom, $urandom};
        @(negedge clk);
        check("t4_w2", 64'(strobes), 64'b00100);
        #1;
        reset = 1'b0;
        #1;
        check("t4_rst_strobes", 64'(strobes), 64'd0);
        check("t4_rst_count", 64'(pkt_count), 64'd0);
        check("t4_rst_short", 64'(pkt_short), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Remainder of the interrupted packet must be ignored.
        bus_word(8'h00, 5'd0, "t4_rem");
        bus_word(8'h00, 5'd0, "t4_rem");
        bus_word(8'h00, 5'd0, "t4_rem");
        bus_word(8'h01, 5'd0, "t4_rem_eop");
        check("t4_rem_short", 64'(pkt_short), 64'd0);
        check("t4_rem_count", 64'(pkt_count), 64'd0);
        send_pkt(2, 7, 8'h01, 0, "t4_next");
        check("t4_next_count", 64'(pkt_count), 64'd1);
        idle(1, "t4_idle");

        // Back-to-back packets from a fresh reset.
        reset = 1'b0;
        #1;
        check("t6_rst_count", 64'(pkt_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_pkt(1, 6, 8'h01, 0, "t6_a");
        send_pkt(1, 6, 8'h01, 0, "t6_b");
        check("t6_count", 64'(pkt_count), 64'd2);
        check("t6_short", 64'(pkt_short), 64'd0);
        idle(1, "t6_idle");

        // Counter wrap: preload 0xFFFFFFFF, one more packet gives 0.
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_q;
        #1;
        check("t5_preload", 64'(pkt_count), 64'hFFFF_FFFF);
        send_pkt(2, 6, 8'h01, 0, "t5");
        check("t5_wrap", 64'(pkt_count), 64'd0);
        idle(2, "t5_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_router_preprocess_ctrl
`default_nettype wire

// File: doc/router_preprocess_ctrl.md
ROUTER_PREPROCESS_CTRL -- requirements
Module: router_preprocess_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 64, datapath width in bits.
REQ-002 Parameter CTRL_WIDTH, DATA_WIDTH/8, control bus width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_data  input  DATA_WIDTH  packet word on the pipeline bus.
REQ-006 in_ctrl  input  CTRL_WIDTH  0 = packet data word; nonzero = module header (before packet) or end-of-packet marker (inside packet).
REQ-007 in_wr  input  1  in_data/in_ctrl valid this cycle.
REQ-008 word_ETH_DST  output  1  word 0 of packet present on in_data.
REQ-009 word_ETH_SRC_TYPE  output  1  word 1 present.
REQ-010 word_IP_LEN_ID  output  1  word 2 present.
REQ-011 word_IP_SRC_DST  output  1  word 3 present (IP src, dst[31:16] in in_data[15:0]).
REQ-012 word_IP_DST_LO  output  1  word 4 present (dst[15:0] in in_data[63:48]).
REQ-013 pkt_short  output  1  one-cycle pulse: packet ended before word 4.
REQ-014 pkt_count  output  32  number of packets whose word 4 was seen.

Function
REQ-015 Block SHALL be a pure observer: never stalls or modifies the bus.
REQ-016 States: MODULE_HDRS, WORD_1, WORD_2, WORD_3, WORD_4, WAIT_EOP.
REQ-017 MODULE_HDRS: in_wr with in_ctrl!=0 stays; in_wr with in_ctrl==0 asserts word_ETH_DST same cycle and moves to WORD_1.
REQ-018 WORD_n (n=1..4): in_wr with in_ctrl==0 asserts the matching word strobe same cycle and advances (WORD_4 -> WAIT_EOP).
REQ-019 Strobes SHALL be combinational from registered state, in_wr and in_ctrl, aligned with the word on in_data, and 0 when in_wr=0.
REQ-020 At most one word strobe SHALL be high in any cycle.
REQ-021 WAIT_EOP: in_wr with in_ctrl!=0 (last word) returns to MODULE_HDRS; other words ignored.
REQ-022 In WORD_1..WORD_4, in_wr with in_ctrl!=0 (EOP before word 4): no strobe, pkt_short pulses next cycle, return to MODULE_HDRS.
REQ-023 in_wr=0 cycles SHALL hold state in every state (gaps inside a packet tolerated).
REQ-024 pkt_count increments by 1, registered, on the cycle after word_IP_DST_LO; wraps 0xFFFFFFFF -> 0.
REQ-025 pkt_short and pkt_count outputs are registered; strobe latency 0 cycles, pkt_short/pkt_count latency 1 cycle.
REQ-026 A module-header word arriving in WAIT_EOP is treated as EOP (in_ctrl!=0), no special case.

Reset
REQ-027 On reset=0, asynchronously: state=MODULE_HDRS, pkt_short=0, pkt_count=0; all strobes 0 while reset asserted.
REQ-028 Reset mid-packet discards the packet; after release, words are ignored until the next in_ctrl!=0 -> in_ctrl==0 sequence (state MODULE_HDRS needs one ctrl==0 word, which is treated as word 0).
REQ-029 Reset deassertion SHALL be synchronised externally; block adds no synchroniser.

Structure
REQ-030 State encodings and word-index constants (0..4) SHALL live in the shared router defines include, used also by downstream filters.
REQ-031 No sub-module; single always block for state/counter, one combinational block for strobes.

Verification
REQ-032 2 module headers (ctrl 0xFF) then 8 data words, last ctrl=0x01 -> strobes word0..word4 on data cycles 1..5 exactly once each, pkt_count 0->1.
REQ-033 Same packet with in_wr=0 gaps of 3 cycles between every word -> identical strobe sequence, no strobe in gap cycles.
REQ-034 Packet of 3 data words, third with ctrl=0x04 -> strobes word0, word1 only; pkt_short=1 for one cycle; next normal packet strobes correctly.
REQ-035 Reset pulled low during word 2 of a packet -> outputs 0 immediately; after release, remainder ignored, following packet fully strobed, pkt_count=1.
REQ-036 Preload pkt_count to 0xFFFFFFFF via 2^32-1 packets (or force) then one packet -> pkt_count=0.
REQ-037 Back-to-back packets, EOP word followed next cycle by header 0xFF then data -> second packet strobed correctly, pkt_count=2.
